// File: rtl/oflow_pe_set_scheduler.sv
// ---------------------------------------------------------------------------
// oflow_pe_set_scheduler
//
// Splits a frame of bounding boxes into sets of at most PE_NUM boxes and runs
// each set on the PE array. For every set the scheduler waits for the DMA to
// present feature data, pulses pe_start with a mask of the PEs in use, and
// collects the per-PE done pulses. When all PEs of the last set are done, it
// raises frame_done for one cycle.
//
// Ports
//   clk                   in   single clock, rising edge
//   reset_N               in   synchronous active-low reset
//   start_frame           in   one-cycle frame request (accepted only in IDLE)
//   num_of_bbox_in_frame  in   [BBOX_W] bbox count, sampled with start_frame
//   abort                 in   abandon the current frame
//   frame_ready           out  idle and able to accept start_frame
//   set_valid_from_dma    in   DMA holds a set
//   set_ready_to_dma      out  scheduler waits for a set
//   pe_start              out  one-cycle start pulse to the PE array
//   pe_enable_mask        out  [PE_NUM] PEs active in the current set
//   pe_done               in   [PE_NUM] per-PE done pulses
//   set_idx               out  [SET_W] index of the current set
//   bbox_remain           out  [BBOX_W] bboxes not yet completed
//   frame_done            out  one-cycle pulse after the last set completes
//   busy                  out  high outside IDLE
// ---------------------------------------------------------------------------
module oflow_pe_set_scheduler #(
    parameter int PE_NUM = 24,
    parameter int BBOX_W = 10,
    parameter int SET_W  = 6
) (
    input  logic              clk,
    input  logic              reset_N,
    input  logic              start_frame,
    input  logic [BBOX_W-1:0] num_of_bbox_in_frame,
    input  logic              abort,
    output logic              frame_ready,
    input  logic              set_valid_from_dma,
    output logic              set_ready_to_dma,
    output logic              pe_start,
    output logic [PE_NUM-1:0] pe_enable_mask,
    input  logic [PE_NUM-1:0] pe_done,
    output logic [SET_W-1:0]  set_idx,
    output logic [BBOX_W-1:0] bbox_remain,
    output logic              frame_done,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SET,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [BBOX_W-1:0] PE_NUM_B = BBOX_W'(PE_NUM);

    state_t            r_state;
    state_t            w_state_next;

    logic              r_pe_start;
    logic              r_frame_done;
    logic [PE_NUM-1:0] r_mask;
    logic [PE_NUM-1:0] r_acc;
    logic [SET_W-1:0]  r_set_idx;
    logic [BBOX_W-1:0] r_bbox_remain;
    logic [BBOX_W-1:0] r_active;

    logic              w_handshake;
    logic              w_set_complete;
    logic              w_last_set;
    logic [BBOX_W-1:0] w_active;
    logic [PE_NUM-1:0] w_mask_next;
    logic [PE_NUM-1:0] w_acc_merged;

    // Size of the next set: whatever is left, capped at the array width.
    assign w_active = (r_bbox_remain > PE_NUM_B) ? PE_NUM_B : r_bbox_remain;

    // Done pulses of PEs outside the mask never reach the accumulator, and
    // the current cycle's pulses count toward completion immediately.
    assign w_acc_merged   = r_acc | (pe_done & r_mask);
    assign w_set_complete = (r_state == S_RUN) && (w_acc_merged == r_mask);
    assign w_handshake    = (r_state == S_WAIT_SET) && set_valid_from_dma && !abort;
    assign w_last_set     = (r_bbox_remain == r_active);

    // Thermometer mask: the low w_active bits set.
    always_comb begin
        w_mask_next = '0;
        for (int i = 0; i < PE_NUM; i++) begin
            w_mask_next[i] = (i < int'(w_active));
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments only, and reset is
    // sampled on the clock edge, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!reset_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort wins over handshake and completion.
    // NOTE: w_state_next gets a default before the case so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_frame) begin
                    w_state_next = (num_of_bbox_in_frame == '0) ? S_DONE : S_WAIT_SET;
                end
            end
            S_WAIT_SET: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (set_valid_from_dma) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_set_complete) begin
                    w_state_next = w_last_set ? S_DONE : S_WAIT_SET;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_N) begin
            r_pe_start    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_mask        <= '0;
            r_acc         <= '0;
            r_set_idx     <= '0;
            r_bbox_remain <= '0;
            r_active      <= '0;
        end else begin
            r_pe_start   <= 1'b0;
            // frame_done trails the DONE state by one cycle; an abort taken
            // in DONE suppresses it.
            r_frame_done <= (r_state == S_DONE) && !abort;

            if (r_state == S_RUN) begin
                r_acc <= w_acc_merged;
            end

            if (r_state == S_IDLE) begin
                if (start_frame) begin
                    r_bbox_remain <= num_of_bbox_in_frame;
                    r_set_idx     <= '0;
                end
            end else if (abort) begin
                // bbox_remain and set_idx are left as they were for inspection.
                r_mask <= '0;
            end else if (w_handshake) begin
                r_mask     <= w_mask_next;
                r_active   <= w_active;
                r_pe_start <= 1'b1;
                r_acc      <= '0;
            end else if (w_set_complete) begin
                // r_active never exceeds r_bbox_remain, so no underflow.
                r_bbox_remain <= r_bbox_remain - r_active;
                r_set_idx     <= r_set_idx + SET_W'(1);
            end else if (r_state == S_DONE) begin
                r_mask <= '0;
            end
        end
    end

    assign frame_ready      = (r_state == S_IDLE);
    assign set_ready_to_dma = (r_state == S_WAIT_SET);
    assign busy             = (r_state != S_IDLE);
    assign pe_start         = r_pe_start;
    assign pe_enable_mask   = r_mask;
    assign set_idx          = r_set_idx;
    assign bbox_remain      = r_bbox_remain;
    assign frame_done       = r_frame_done;

endmodule

// File: tb/tb_oflow_pe_set_scheduler.sv
// ---------------------------------------------------------------------------
// tb_oflow_pe_set_scheduler
//
// Self-checking bench for oflow_pe_set_scheduler with default parameters.
// A reference model splits each requested frame into sets and pushes the
// expected (mask, set_idx, bbox_remain) of every set onto a queue; a monitor
// pops and compares one entry on every pe_start. Directed sequences cover the
// multi-set frame, the single full set, the empty frame, staggered and
// spurious done pulses, reset mid-run and abort racing completion.
// ---------------------------------------------------------------------------
module tb_oflow_pe_set_scheduler;

    localparam int PE_NUM = 24;
    localparam int BBOX_W = 10;
    localparam int SET_W  = 6;

    logic              clk;
    logic              reset_N;
    logic              start_frame;
    logic [BBOX_W-1:0] num_of_bbox_in_frame;
    logic              abort;
    logic              frame_ready;
    logic              set_valid_from_dma;
    logic              set_ready_to_dma;
    logic              pe_start;
    logic [PE_NUM-1:0] pe_enable_mask;
    logic [PE_NUM-1:0] pe_done;
    logic [SET_W-1:0]  set_idx;
    logic [BBOX_W-1:0] bbox_remain;
    logic              frame_done;
    logic              busy;

    oflow_pe_set_scheduler #(
        .PE_NUM (PE_NUM),
        .BBOX_W (BBOX_W),
        .SET_W  (SET_W)
    ) dut (
        .clk                  (clk),
        .reset_N              (reset_N),
        .start_frame          (start_frame),
        .num_of_bbox_in_frame (num_of_bbox_in_frame),
        .abort                (abort),
        .frame_ready          (frame_ready),
        .set_valid_from_dma   (set_valid_from_dma),
        .set_ready_to_dma     (set_ready_to_dma),
        .pe_start             (pe_start),
        .pe_enable_mask       (pe_enable_mask),
        .pe_done              (pe_done),
        .set_idx              (set_idx),
        .bbox_remain          (bbox_remain),
        .frame_done           (frame_done),
        .busy                 (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [PE_NUM-1:0] mask;
        logic [SET_W-1:0]  idx;
        logic [BBOX_W-1:0] remain;
    } set_exp_t;

    set_exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt   = 0;
    bit auto_pe  = 1'b0;
    int resp_cnt = 0;
    logic [PE_NUM-1:0] resp_mask = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: split num bboxes into sets of at most PE_NUM.
    task automatic push_frame(input int num);
        int remain;
        int idx;
        int act;
        set_exp_t e;
        remain = num;
        idx    = 0;
        while (remain > 0) begin
            act      = (remain > PE_NUM) ? PE_NUM : remain;
            e.mask   = PE_NUM'((64'd1 << act) - 64'd1);
            e.idx    = SET_W'(idx);
            e.remain = BBOX_W'(remain);
            exp_q.push_back(e);
            remain -= act;
            idx++;
        end
    endtask

    // Called at a negedge; returns at the negedge after start was sampled.
    task automatic start(input int num);
        push_frame(num);
        start_frame          = 1'b1;
        num_of_bbox_in_frame = BBOX_W'(num);
        @(negedge clk);
        start_frame = 1'b0;
    endtask

    task automatic wait_pe_start(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pe_start && n < 100);
        check(tag, 32'(pe_start), 32'd1);
    endtask

    task automatic wait_frame_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 300);
        check(tag, 32'(frame_done), 32'd1);
    endtask

    // Scoreboard: every pe_start must match the next modelled set.
    always @(negedge clk) begin
        if (reset_N && pe_start) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pe_start", 32'(pe_start), 32'd0);
            end else begin
                set_exp_t e;
                e = exp_q.pop_front();
                check("sb_mask",   32'(pe_enable_mask), 32'(e.mask));
                check("sb_set_idx", 32'(set_idx),       32'(e.idx));
                check("sb_remain", 32'(bbox_remain),    32'(e.remain));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_N && frame_done) fd_cnt++;
    end

    // Automatic PE model: all enabled PEs report done 3 cycles after pe_start.
    always @(negedge clk) begin
        if (!reset_N) begin
            resp_cnt = 0;
        end else if (auto_pe) begin
            pe_done = '0;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) pe_done = resp_mask;
            end
            if (pe_start) begin
                resp_cnt  = 3;
                resp_mask = pe_enable_mask;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        int fd0;
        bit saw;

        reset_N              = 1'b0;
        start_frame          = 1'b0;
        num_of_bbox_in_frame = '0;
        abort                = 1'b0;
        set_valid_from_dma   = 1'b0;
        pe_done              = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_frame_ready", 32'(frame_ready),      32'd1);
        check("rst_set_ready",   32'(set_ready_to_dma), 32'd0);
        check("rst_pe_start",    32'(pe_start),         32'd0);
        check("rst_mask",        32'(pe_enable_mask),   32'd0);
        check("rst_set_idx",     32'(set_idx),          32'd0);
        check("rst_bbox_remain", 32'(bbox_remain),      32'd0);
        check("rst_frame_done",  32'(frame_done),       32'd0);
        check("rst_busy",        32'(busy),             32'd0);
        reset_N = 1'b1;
        @(negedge clk);

        // ---------------- num=50, three sets ----------------
        auto_pe            = 1'b1;
        set_valid_from_dma = 1'b1;
        fd0 = fd_cnt;
        start(50);
        check("a_bbox_after_start", 32'(bbox_remain),      32'd50);
        check("a_set_ready",        32'(set_ready_to_dma), 32'd1);
        check("a_busy",             32'(busy),             32'd1);
        wait_frame_done("a_frame_done_seen");
        repeat (3) @(negedge clk);
        check("a_frame_done_count", 32'(fd_cnt - fd0), 32'd1);
        check("a_queue_drained",    32'(exp_q.size()), 32'd0);
        check("a_bbox_final",       32'(bbox_remain),  32'd0);
        check("a_set_idx_final",    32'(set_idx),      32'd3);
        check("a_mask_cleared",     32'(pe_enable_mask), 32'd0);

        // ---------------- num=24, single full set, latency ----------------
        start(24);
        wait_pe_start("b_pe_start_seen");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 50);
        check("b_frame_done_latency", 32'(n), 32'd5);
        @(negedge clk);
        check("b_frame_ready_after", 32'(frame_ready), 32'd1);
        check("b_frame_done_pulse",  32'(frame_done),  32'd0);

        // ---------------- num=0, empty frame ----------------
        saw = 1'b0;
        start_frame          = 1'b1;
        num_of_bbox_in_frame = '0;
        n = 0;
        do begin
            @(negedge clk);
            start_frame = 1'b0;
            n++;
            saw = saw | set_ready_to_dma | pe_start;
        end while (!frame_done && n < 20);
        check("c_frame_done_latency", 32'(n),   32'd2);
        check("c_no_ready_no_start",  32'(saw), 32'd0);
        @(negedge clk);

        // ---------------- num=5, staggered done + spurious bit 10 ----------------
        auto_pe = 1'b0;
        start(5);
        wait_pe_start("d_pe_start_seen");
        pe_done = PE_NUM'(1 << 0);
        @(negedge clk);
        check("d_not_done_1", 32'(bbox_remain), 32'd5);
        pe_done              = PE_NUM'((1 << 1) | (1 << 10));
        start_frame          = 1'b1;              // must be ignored while busy
        num_of_bbox_in_frame = BBOX_W'(7);
        @(negedge clk);
        start_frame = 1'b0;
        check("d_not_done_2", 32'(bbox_remain), 32'd5);
        pe_done = PE_NUM'((1 << 2) | (1 << 1));   // repeated bit 1
        @(negedge clk);
        check("d_not_done_3", 32'(bbox_remain), 32'd5);
        check("d_still_busy", 32'(busy),        32'd1);
        pe_done = PE_NUM'((1 << 3) | (1 << 4));
        @(negedge clk);
        pe_done = '0;
        check("d_done_bbox",    32'(bbox_remain), 32'd0);
        check("d_done_set_idx", 32'(set_idx),     32'd1);
        wait_frame_done("d_frame_done_seen");
        @(negedge clk);

        // ---------------- reset during RUN of set 1 ----------------
        auto_pe = 1'b1;
        start(50);
        wait_pe_start("e_pe_start_set0");
        wait_pe_start("e_pe_start_set1");
        check("e_in_set1", 32'(set_idx), 32'd1);
        reset_N = 1'b0;
        @(negedge clk);
        check("e_rst_frame_ready", 32'(frame_ready),      32'd1);
        check("e_rst_set_ready",   32'(set_ready_to_dma), 32'd0);
        check("e_rst_pe_start",    32'(pe_start),         32'd0);
        check("e_rst_mask",        32'(pe_enable_mask),   32'd0);
        check("e_rst_set_idx",     32'(set_idx),          32'd0);
        check("e_rst_bbox_remain", 32'(bbox_remain),      32'd0);
        check("e_rst_busy",        32'(busy),             32'd0);
        exp_q.delete();
        fd0 = fd_cnt;
        @(negedge clk);
        reset_N = 1'b1;
        repeat (6) @(negedge clk);
        check("e_no_frame_done_after_rst", 32'(fd_cnt - fd0), 32'd0);
        start(3);
        wait_frame_done("e_frame3_done");
        check("e_queue_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk);

        // ---------------- abort in the completion cycle ----------------
        auto_pe = 1'b0;
        pe_done = '0;
        fd0 = fd_cnt;
        start(50);
        wait_pe_start("f_pe_start_seen");
        pe_done = '1;
        abort   = 1'b1;
        @(negedge clk);
        pe_done = '0;
        abort   = 1'b0;
        check("f_idle",        32'(busy),           32'd0);
        check("f_frame_ready", 32'(frame_ready),    32'd1);
        check("f_set_idx",     32'(set_idx),        32'd0);
        check("f_bbox_kept",   32'(bbox_remain),    32'd50);
        check("f_mask_clear",  32'(pe_enable_mask), 32'd0);
        exp_q.delete();
        repeat (8) @(negedge clk);
        check("f_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
        check("f_still_idle",    32'(busy),         32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
